ex_stage_pipe: RTL and testbench
================================

// Module: ex_stage_pipe
// PURPOSE
//  Parametrised RV32I-class execute stage with a registered EX/MEM pipeline register.
//  Sits between ID/EX and the MEM stage; operand forwarding from MEM and WB, full integer ALU,
//  branch resolution, valid/ready stall handshake and flush. Replaces the fixed 32-bit AND/OR/ADD/SUB EX stage.
// PARAMETERS
//  XLEN     32  datapath width (power of 2, >=8); shift amount = low $clog2(XLEN) bits of operand B
//  REG_AW   5   register-file address width
//  FWD_EN   1   1: forwarding muxes present; 0: rs1/rs2 data used directly, fwd ports ignored
// PORTS
//  clock           in   1       single clock, rising edge
//  reset_n         in   1       asynchronous, active-low reset
//  in_valid        in   1       ID/EX holds a valid instruction
//  in_ready        out  1       stage can accept this cycle
//  flush           in   1       kill contents of EX/MEM register and the incoming instruction
//  controls        in   8       [7:6] WB{regWrite,memToReg} [5:3] M{branch,memRead,memWrite} [2:1] aluop [0] alusrc
//  pc              in   XLEN    PC of instruction
//  imm             in   XLEN    sign-extended immediate
//  rs1_data/rs2_data in XLEN    register-file read data
//  rs1/rs2/rd      in   REG_AW  source/destination register indices
//  funct3          in   3       instruction funct3
//  funct7          in   7       instruction funct7
//  mem_fwd_we/_rd/_data in 1/REG_AW/XLEN  MEM-stage writeback candidate
//  wb_fwd_we/_rd/_data  in 1/REG_AW/XLEN  WB-stage writeback candidate
//  out_valid       out  1       EX/MEM register valid
//  out_ready       in   1       MEM stage accepts this cycle
//  out_alu         out  XLEN    registered ALU result
//  out_zero        out  1       out_alu == 0
//  out_pc_branch   out  XLEN    registered pc + imm (modulo 2^XLEN)
//  out_br_taken    out  1       registered branch-taken (valid instr only)
//  out_ctrl_wb/_m  out  2/3     registered control groups
//  out_store_data  out  XLEN    forwarded rs2 value, registered
//  out_rd          out  REG_AW  registered destination
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs/registers 0; in_ready=1 on release.
//  - in_ready = ~out_valid | out_ready (combinational). Capture on in_valid & in_ready; latency 1 cycle.
//  - Stall: out_valid & ~out_ready -> every out_* holds; in_ready=0.
//  - Flush: next edge out_valid=0, incoming instruction discarded; flush beats capture and stall.
//  - No capture & out_ready: out_valid->0; data regs may hold stale values.
//  - Forwarding (FWD_EN=1), per source: rd==0 never forwarded; MEM match beats WB match beats regfile.
//  - Operand B = alusrc ? imm : fwd_rs2. Store data always fwd_rs2.
//  - aluop 00 ADD; 01 SUB; 11 pass operand B (LUI); 10 decode funct3:
//    000 ADD, or SUB if funct7[5]&~alusrc; 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR;
//    101 SRL, or SRA if funct7[5]; 110 OR; 111 AND. All arithmetic wraps modulo 2^XLEN.
//  - Branch compare on forwarded rs1 vs rs2 by funct3: 000 EQ,001 NE,100 LT,101 GE,110 LTU,111 GEU;
//    010/011 -> not taken. out_br_taken = captured & M.branch & cond.
//  - out_zero derived from the registered out_alu (no extra latency).
//  - Reset asserted mid-stall: outputs 0 immediately; held instruction lost.
// STRUCTURE
//  - ex_pkg: ALU op enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,PASSB), controls bit indices, funct3 branch codes.
//  - Sub-module ex_alu (combinational: op, a, b -> result); ALU decode, forwarding, branch compare and
//    pipeline register stay in ex_stage_pipe.
// TESTING
//  1 Reset: reset_n=0 mid-run -> all outputs 0 same cycle; after release in_ready=1, out_valid=0.
//  2 ALU: aluop=10,f3=000,f7=0x20,alusrc=0,rs1=5,rs2=7 -> next cycle out_alu=0xFFFFFFFE, zero=0;
//    f3=101,f7=0x20,rs1=0x80000000,imm=4,alusrc=1 -> 0xF8000000; f3=011,rs1=1,rs2=0xFFFFFFFF -> 1.
//  3 Forwarding: rs1=3, mem_fwd(we=1,rd=3,0x10) and wb_fwd(we=1,rd=3,0x20), rs1_data=0x30, ADD imm=1
//    -> out_alu=0x11; same with rd=0 -> 0x31.
//  4 Branch: M.branch=1,f3=100,rs1=-1,rs2=0,pc=0x100,imm=0xFFFFFFF8 -> out_br_taken=1,out_pc_branch=0xF8;
//    f3=110 same operands -> out_br_taken=0.
//  5 Stall/flush: out_ready=0 three cycles with in_valid=1 -> outputs stable, in_ready=0;
//    flush with out_ready=0 -> next cycle out_valid=0, new instr not captured.
//  6 XLEN=16: ADD 0xFFFF+1 -> out_alu=0, out_zero=1; SLL by 17 uses shamt 1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation encoding, control-byte
// field positions and branch funct3 codes.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_e;

    // controls byte: [7:6] WB{regWrite,memToReg} [5:3] M{branch,memRead,memWrite} [2:1] aluop [0] alusrc
    localparam int CTL_WB_HI    = 7;
    localparam int CTL_WB_LO    = 6;
    localparam int CTL_M_HI     = 5;
    localparam int CTL_M_LO     = 3;
    localparam int CTL_BRANCH   = 5;
    localparam int CTL_ALUOP_HI = 2;
    localparam int CTL_ALUOP_LO = 1;
    localparam int CTL_ALUSRC   = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU; shifts use only the low $clog2(XLEN) bits of operand B.
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e           i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU decode, branch resolution and the EX/MEM
// register with a valid/ready handshake and flush.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [7:0]        controls,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu,
    output logic              out_zero,
    output logic [XLEN-1:0]   out_pc_branch,
    output logic              out_br_taken,
    output logic [1:0]        out_ctrl_wb,
    output logic [2:0]        out_ctrl_m,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_rd
);

    logic [XLEN-1:0]   w_fwd_rs1, w_fwd_rs2, w_op_b, w_alu_res;
    logic [1:0]        w_aluop;
    logic              w_alusrc, w_br_cond, w_capture;
    alu_op_e           w_alu_op;
    logic              w_unused_f7;

    logic              r_valid, r_br_taken;
    logic [XLEN-1:0]   r_alu, r_pc_branch, r_store;
    logic [1:0]        r_ctrl_wb;
    logic [2:0]        r_ctrl_m;
    logic [REG_AW-1:0] r_rd;

    assign w_aluop     = controls[CTL_ALUOP_HI:CTL_ALUOP_LO];
    assign w_alusrc    = controls[CTL_ALUSRC];
    assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

    // x0 is hard-wired, so a writeback naming it must never override the register file.
    always_comb begin
        w_fwd_rs1 = rs1_data;
        w_fwd_rs2 = rs2_data;
        if (FWD_EN) begin
            if (rs1 != '0) begin
                if (mem_fwd_we && (mem_fwd_rd == rs1))     w_fwd_rs1 = mem_fwd_data;
                else if (wb_fwd_we && (wb_fwd_rd == rs1))  w_fwd_rs1 = wb_fwd_data;
            end
            if (rs2 != '0) begin
                if (mem_fwd_we && (mem_fwd_rd == rs2))     w_fwd_rs2 = mem_fwd_data;
                else if (wb_fwd_we && (wb_fwd_rd == rs2))  w_fwd_rs2 = wb_fwd_data;
            end
        end
    end

    assign w_op_b = w_alusrc ? imm : w_fwd_rs2;

    always_comb begin
        w_alu_op = ALU_ADD;
        case (w_aluop)
            ALUOP_ADD:   w_alu_op = ALU_ADD;
            ALUOP_SUB:   w_alu_op = ALU_SUB;
            ALUOP_PASSB: w_alu_op = ALU_PASSB;
            default: begin
                case (funct3)
                    3'b000:  w_alu_op = (funct7[5] && !w_alusrc) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_alu_op = ALU_SLL;
                    3'b010:  w_alu_op = ALU_SLT;
                    3'b011:  w_alu_op = ALU_SLTU;
                    3'b100:  w_alu_op = ALU_XOR;
                    3'b101:  w_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
        endcase
    end

    ex_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (w_alu_op),
        .i_a      (w_fwd_rs1),
        .i_b      (w_op_b),
        .o_result (w_alu_res)
    );

    always_comb begin
        w_br_cond = 1'b0;
        case (funct3)
            BR_EQ:   w_br_cond = (w_fwd_rs1 == w_fwd_rs2);
            BR_NE:   w_br_cond = (w_fwd_rs1 != w_fwd_rs2);
            BR_LT:   w_br_cond = ($signed(w_fwd_rs1) <  $signed(w_fwd_rs2));
            BR_GE:   w_br_cond = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
            BR_LTU:  w_br_cond = (w_fwd_rs1 <  w_fwd_rs2);
            BR_GEU:  w_br_cond = (w_fwd_rs1 >= w_fwd_rs2);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign in_ready  = ~r_valid | out_ready;
    assign w_capture = in_valid & in_ready;

    // Branch-taken is cleared whenever the register empties so it never outlives its instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_alu       <= '0;
            r_pc_branch <= '0;
            r_store     <= '0;
            r_ctrl_wb   <= '0;
            r_ctrl_m    <= '0;
            r_rd        <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_br_taken <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_br_taken  <= controls[CTL_BRANCH] & w_br_cond;
            r_alu       <= w_alu_res;
            r_pc_branch <= pc + imm;
            r_store     <= w_fwd_rs2;
            r_ctrl_wb   <= controls[CTL_WB_HI:CTL_WB_LO];
            r_ctrl_m    <= controls[CTL_M_HI:CTL_M_LO];
            r_rd        <= rd;
        end else if (out_ready) begin
            r_valid    <= 1'b0;
            r_br_taken <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_alu        = r_alu;
    assign out_zero       = (r_alu == '0);
    assign out_pc_branch  = r_pc_branch;
    assign out_br_taken   = r_br_taken;
    assign out_ctrl_wb    = r_ctrl_wb;
    assign out_ctrl_m     = r_ctrl_m;
    assign out_store_data = r_store;
    assign out_rd         = r_rd;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: a 32-bit instance for the full feature set and a
// 16-bit instance for narrow-datapath wrap and shift-amount masking.
module tb_ex_stage_pipe;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] pcb;
        logic        br;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] st;
        logic [4:0]  rd;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [7:0]  controls = '0;
    logic [31:0] pc = '0, imm = '0, rs1_data = '0, rs2_data = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        mem_fwd_we = 1'b0, wb_fwd_we = 1'b0;
    logic [4:0]  mem_fwd_rd = '0, wb_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
    logic        in_ready, out_valid, out_zero, out_br_taken;
    logic [31:0] out_alu, out_pc_branch, out_store_data;
    logic [1:0]  out_ctrl_wb;
    logic [2:0]  out_ctrl_m;
    logic [4:0]  out_rd;

    logic        h_in_valid = 1'b0, h_out_ready = 1'b1;
    logic [7:0]  h_controls = '0;
    logic [15:0] h_rs1_data = '0, h_rs2_data = '0, h_imm = '0;
    logic [2:0]  h_funct3 = '0;
    logic [6:0]  h_funct7 = '0;
    logic        h_in_ready, h_out_valid, h_out_zero, h_out_br_taken;
    logic [15:0] h_out_alu, h_out_pc_branch, h_out_store_data;
    logic [1:0]  h_out_ctrl_wb;
    logic [2:0]  h_out_ctrl_m;
    logic [4:0]  h_out_rd;

    exp_t        sb[$];
    logic [16:0] sb16[$];
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    ex_stage_pipe #(.XLEN(32), .REG_AW(5), .FWD_EN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .controls(controls), .pc(pc), .imm(imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu), .out_zero(out_zero),
        .out_pc_branch(out_pc_branch), .out_br_taken(out_br_taken),
        .out_ctrl_wb(out_ctrl_wb), .out_ctrl_m(out_ctrl_m),
        .out_store_data(out_store_data), .out_rd(out_rd)
    );

    ex_stage_pipe #(.XLEN(16), .REG_AW(5), .FWD_EN(1'b1)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .flush(1'b0), .controls(h_controls), .pc(16'h0000), .imm(h_imm),
        .rs1_data(h_rs1_data), .rs2_data(h_rs2_data), .rs1(5'd1), .rs2(5'd2), .rd(5'd3),
        .funct3(h_funct3), .funct7(h_funct7),
        .mem_fwd_we(1'b0), .mem_fwd_rd(5'd0), .mem_fwd_data(16'h0000),
        .wb_fwd_we(1'b0), .wb_fwd_rd(5'd0), .wb_fwd_data(16'h0000),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_alu(h_out_alu),
        .out_zero(h_out_zero), .out_pc_branch(h_out_pc_branch), .out_br_taken(h_out_br_taken),
        .out_ctrl_wb(h_out_ctrl_wb), .out_ctrl_m(h_out_ctrl_m),
        .out_store_data(h_out_store_data), .out_rd(h_out_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=1 alu=0x%08h expected no output", out_alu);
            end else begin
                exp_t e;
                logic bad;
                e = sb.pop_front();
                bad = 1'b0;
                if (out_alu !== e.alu) begin bad = 1'b1; $display("FAIL alu: got 0x%08h expected 0x%08h", out_alu, e.alu); end
                if (out_zero !== e.zero) begin bad = 1'b1; $display("FAIL zero: got %0b expected %0b", out_zero, e.zero); end
                if (out_pc_branch !== e.pcb) begin bad = 1'b1; $display("FAIL pc_branch: got 0x%08h expected 0x%08h", out_pc_branch, e.pcb); end
                if (out_br_taken !== e.br) begin bad = 1'b1; $display("FAIL br_taken: got %0b expected %0b", out_br_taken, e.br); end
                if (out_ctrl_wb !== e.wb) begin bad = 1'b1; $display("FAIL ctrl_wb: got %0b expected %0b", out_ctrl_wb, e.wb); end
                if (out_ctrl_m !== e.m) begin bad = 1'b1; $display("FAIL ctrl_m: got %0b expected %0b", out_ctrl_m, e.m); end
                if (out_store_data !== e.st) begin bad = 1'b1; $display("FAIL store_data: got 0x%08h expected 0x%08h", out_store_data, e.st); end
                if (out_rd !== e.rd) begin bad = 1'b1; $display("FAIL rd: got %0d expected %0d", out_rd, e.rd); end
                if (bad) n_fail++;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && h_out_valid && h_out_ready) begin
            n_vec++;
            if (sb16.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output16: got alu=0x%04h expected no output", h_out_alu);
            end else begin
                logic [16:0] e16;
                e16 = sb16.pop_front();
                if ({h_out_zero, h_out_alu} !== e16) begin
                    n_fail++;
                    $display("FAIL alu16: got zero=%0b alu=0x%04h expected zero=%0b alu=0x%04h",
                             h_out_zero, h_out_alu, e16[16], e16[15:0]);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] ctl, input logic [31:0] pcv, immv, r1d, r2d,
                         input logic [4:0] a1, a2, d, input logic [2:0] f3, input logic [6:0] f7);
        controls = ctl; pc = pcv; imm = immv; rs1_data = r1d; rs2_data = r2d;
        rs1 = a1; rs2 = a2; rd = d; funct3 = f3; funct7 = f7;
        in_valid = 1'b1;
    endtask

    function automatic exp_t mk(input logic [7:0] ctl, input logic [4:0] d,
                                input logic [31:0] alu, pcb, st, input logic br);
        exp_t e;
        e.alu = alu; e.zero = (alu == 32'h0); e.pcb = pcb; e.br = br;
        e.wb = ctl[7:6]; e.m = ctl[5:3]; e.st = st; e.rd = d;
        return e;
    endfunction

    task automatic issue(input logic [7:0] ctl, input logic [31:0] pcv, immv, r1d, r2d,
                         input logic [4:0] a1, a2, d, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] e_alu, e_pcb, e_st, input logic e_br);
        drive(ctl, pcv, immv, r1d, r2d, a1, a2, d, f3, f7);
        sb.push_back(mk(ctl, d, e_alu, e_pcb, e_st, e_br));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue16(input logic [7:0] ctl, input logic [15:0] r1d, r2d, immv,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [16:0] e);
        h_controls = ctl; h_rs1_data = r1d; h_rs2_data = r2d; h_imm = immv;
        h_funct3 = f3; h_funct7 = f7; h_in_valid = 1'b1;
        sb16.push_back(e);
        @(posedge clock); #1;
        h_in_valid = 1'b0;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        mem_fwd_we = mwe; mem_fwd_rd = mrd; mem_fwd_data = md;
        wb_fwd_we = wwe; wb_fwd_rd = wrd; wb_fwd_data = wd;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (((sb.size() != 0) || (sb16.size() != 0)) && (k < 50)) begin
            @(posedge clock); #1;
            k++;
        end
        n_vec++;
        if ((sb.size() != 0) || (sb16.size() != 0)) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", sb.size(), sb16.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        #7;
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_alu", out_alu, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        chk("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("post_reset_valid", {31'h0, out_valid}, 32'h0);

        // ALU coverage: ctl 0x84 = regWrite, aluop 10, alusrc 0; 0x85 same with alusrc 1
        issue(8'h84, 32'h40, 32'h0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 3'b000, 7'h20, 32'hFFFFFFFE, 32'h40, 32'd7, 1'b0);
        issue(8'h85, 32'h44, 32'd4, 32'h80000000, 32'h1234, 5'd1, 5'd2, 5'd4, 3'b101, 7'h20, 32'hF8000000, 32'h48, 32'h1234, 1'b0);
        issue(8'h84, 32'h48, 32'h0, 32'd1, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd5, 3'b011, 7'h00, 32'd1, 32'h48, 32'hFFFFFFFF, 1'b0);
        issue(8'h84, 32'h4C, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 5'd5, 3'b010, 7'h00, 32'd1, 32'h4C, 32'd1, 1'b0);
        issue(8'h84, 32'h0, 32'h0, 32'd1, 32'd33, 5'd1, 5'd2, 5'd6, 3'b001, 7'h00, 32'd2, 32'h0, 32'd33, 1'b0);
        issue(8'h85, 32'h0, 32'd4, 32'h80000000, 32'h0, 5'd1, 5'd2, 5'd6, 3'b101, 7'h00, 32'h08000000, 32'd4, 32'h0, 1'b0);
        issue(8'h84, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 5'd1, 5'd2, 5'd1, 3'b110, 7'h00, 32'hFFF0, 32'h0, 32'hFF00, 1'b0);
        issue(8'h84, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 5'd1, 5'd2, 5'd1, 3'b111, 7'h00, 32'hF000, 32'h0, 32'hFF00, 1'b0);
        issue(8'h85, 32'h0, 32'd5, 32'd10, 32'h0, 5'd1, 5'd2, 5'd2, 3'b000, 7'h20, 32'd15, 32'd5, 32'h0, 1'b0);
        issue(8'h87, 32'h0, 32'hABCDE000, 32'd1, 32'd2, 5'd1, 5'd2, 5'd7, 3'b000, 7'h00, 32'hABCDE000, 32'hABCDE000, 32'd2, 1'b0);

        // Forwarding priority and x0 exclusion
        set_fwd(1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        issue(8'h81, 32'h0, 32'd1, 32'h30, 32'h0, 5'd3, 5'd0, 5'd10, 3'b000, 7'h00, 32'h11, 32'd1, 32'h0, 1'b0);
        set_fwd(1'b0, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
        issue(8'h81, 32'h0, 32'd1, 32'h30, 32'h0, 5'd3, 5'd0, 5'd10, 3'b000, 7'h00, 32'h21, 32'd1, 32'h0, 1'b0);
        set_fwd(1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20);
        issue(8'h81, 32'h0, 32'd1, 32'h30, 32'h0, 5'd0, 5'd0, 5'd10, 3'b000, 7'h00, 32'h31, 32'd1, 32'h0, 1'b0);
        set_fwd(1'b1, 5'd4, 32'h100, 1'b1, 5'd4, 32'h200);
        issue(8'h0C, 32'h0, 32'h0, 32'd2, 32'd9, 5'd1, 5'd4, 5'd0, 3'b000, 7'h00, 32'h102, 32'h0, 32'h100, 1'b0);
        set_fwd(1'b0, 5'd4, 32'h100, 1'b1, 5'd4, 32'h200);
        issue(8'h0C, 32'h0, 32'h0, 32'd2, 32'd9, 5'd1, 5'd4, 5'd0, 3'b000, 7'h00, 32'h202, 32'h0, 32'h200, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Branches: ctl 0x22 = branch, aluop 01; 0x02 = aluop 01 without branch
        issue(8'h22, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 5'd1, 5'd2, 5'd0, 3'b100, 7'h00, 32'hFFFFFFFF, 32'hF8, 32'h0, 1'b1);
        issue(8'h22, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 5'd1, 5'd2, 5'd0, 3'b110, 7'h00, 32'hFFFFFFFF, 32'hF8, 32'h0, 1'b0);
        issue(8'h22, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 5'd1, 5'd2, 5'd0, 3'b111, 7'h00, 32'hFFFFFFFF, 32'hF8, 32'h0, 1'b1);
        issue(8'h22, 32'h100, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h0, 5'd1, 5'd2, 5'd0, 3'b101, 7'h00, 32'hFFFFFFFF, 32'hF8, 32'h0, 1'b0);
        issue(8'h22, 32'h200, 32'h10, 32'd5, 32'd5, 5'd1, 5'd2, 5'd0, 3'b000, 7'h00, 32'h0, 32'h210, 32'd5, 1'b1);
        issue(8'h22, 32'h200, 32'h10, 32'd5, 32'd5, 5'd1, 5'd2, 5'd0, 3'b001, 7'h00, 32'h0, 32'h210, 32'd5, 1'b0);
        issue(8'h22, 32'h200, 32'h10, 32'd1, 32'd2, 5'd1, 5'd2, 5'd0, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h210, 32'd2, 1'b0);
        issue(8'h02, 32'h200, 32'h10, 32'd5, 32'd5, 5'd1, 5'd2, 5'd0, 3'b000, 7'h00, 32'h0, 32'h210, 32'd5, 1'b0);
        drain();

        // Stall: X held while Y waits at the input for three cycles
        out_ready = 1'b0;
        issue(8'h84, 32'h300, 32'h0, 32'h1111, 32'h2222, 5'd1, 5'd2, 5'd7, 3'b000, 7'h00, 32'h3333, 32'h300, 32'h2222, 1'b0);
        drive(8'h84, 32'h304, 32'h0, 32'hF0F0, 32'hFF00, 5'd1, 5'd2, 5'd8, 3'b100, 7'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_alu", out_alu, 32'h3333);
            chk("stall_rd", {27'h0, out_rd}, 32'd7);
            @(posedge clock); #1;
        end
        sb.push_back(mk(8'h84, 5'd8, 32'h0FF0, 32'h304, 32'hFF00, 1'b0));
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        drain();

        // Flush beats both stall and the incoming capture
        out_ready = 1'b0;
        drive(8'h84, 32'h400, 32'h0, 32'd4, 32'd4, 5'd1, 5'd2, 5'd9, 3'b000, 7'h00);
        @(posedge clock); #1;
        drive(8'h84, 32'h404, 32'h0, 32'd6, 32'd6, 5'd1, 5'd2, 5'd11, 3'b000, 7'h00);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        chk("flush_no_capture", {31'h0, out_valid}, 32'h0);

        // Reset asserted while an instruction is stalled in the register
        out_ready = 1'b0;
        drive(8'hCC, 32'h10, 32'd4, 32'd5, 32'd6, 5'd1, 5'd2, 5'd9, 3'b000, 7'h00);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("pre_reset_held", {31'h0, out_valid}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_reset_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_reset_alu", out_alu, 32'h0);
        chk("mid_reset_pcb", out_pc_branch, 32'h0);
        chk("mid_reset_store", out_store_data, 32'h0);
        chk("mid_reset_ctrl", {24'h0, out_ctrl_wb, out_ctrl_m, out_rd[2:0]}, 32'h0);
        chk("mid_reset_rd", {27'h0, out_rd}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("after_reset_valid", {31'h0, out_valid}, 32'h0);
        chk("after_reset_in_ready", {31'h0, in_ready}, 32'h1);

        // 16-bit datapath: wrap to zero, shift amount masked to 4 bits, arithmetic shift
        issue16(8'h84, 16'hFFFF, 16'h0001, 16'h0000, 3'b000, 7'h00, {1'b1, 16'h0000});
        issue16(8'h84, 16'h0001, 16'd17, 16'h0000, 3'b001, 7'h00, {1'b0, 16'h0002});
        issue16(8'h85, 16'h8000, 16'h0000, 16'd4, 3'b101, 7'h20, {1'b0, 16'hF800});
        issue16(8'h84, 16'h0003, 16'h0005, 16'h0000, 3'b000, 7'h20, {1'b0, 16'hFFFE});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
